shift_deserializer: RTL and testbench
=====================================

// Module: shift_deserializer
// PURPOSE
//   Serial-to-parallel stage; sits directly downstream of shift_serializer on the serial link.
//   Samples one bit per cycle when bit_valid_i is high, MSB first, and assembles TO-bit words.
//   Presents each completed word on a valid/ready output port through a one-entry holding register.
//   Assembly of the next word continues while the held word waits.
// PARAMETERS
//   TO    3    word width in bits; must be >= 2 (elaboration-time assertion)
// PORTS
//   clk          in   1       clock; all state updates on posedge
//   reset        in   1       asynchronous, active-high reset
//   bit_i        in   1       serial data bit, MSB of word first
//   bit_valid_i  in   1       bit_i is sampled this cycle; gaps allowed
//   clear_i      in   1       sync resync: abort partial word, clear overflow_o
//   data_o       out  TO      assembled word; stable while valid_o && !ready_i
//   valid_o      out  1       holding register contains a word
//   ready_i      in   1       consumer accepts data_o when valid_o && ready_i
//   overflow_o   out  1       sticky: a completed word was dropped
//   busy_o       out  1       partial word in progress (state != IDLE)
// BEHAVIOUR
//   Reset (async, asserted at any time, including mid-word or mid-handshake):
//     state = IDLE, shift reg = 0, bit counter = 0, data_o = 0,
//     valid_o = 0, overflow_o = 0, busy_o = 0.
//   Counter: width $clog2(TO+1). Counts bits received in the current word.
//   FSM states:
//     IDLE -> SHIFT on bit_valid_i. In that cycle: sr <= {'0, bit_i}, cnt <= 1.
//     SHIFT: each bit_valid_i does sr <= {sr[TO-2:0], bit_i} and cnt <= cnt + 1.
//       Cycles without bit_valid_i hold all state.
//     Completion is the bit_valid_i cycle with cnt == TO-1. The word {sr[TO-2:0], bit_i}
//       goes to the holding register; state -> IDLE, cnt -> 0.
//       With DESER_PARITY_EN the FSM goes to PARITY instead (see CONFIGURATION).
//   Holding register:
//     Loads when a word completes and either (!valid_o) or (valid_o && ready_i) in the same
//       cycle. Simultaneous drain and load gives back-to-back words without a bubble.
//     If a word completes while valid_o && !ready_i, the new word is dropped, overflow_o <= 1,
//       and data_o is unchanged.
//     valid_o clears the cycle after a handshake when no new word loads.
//   Latency: valid_o rises the cycle after the last bit is sampled.
//     With a continuous bit stream, throughput is one word per TO cycles (TO+1 with parity).
//   clear_i has priority over bit_valid_i: the bit is discarded, state -> IDLE, cnt -> 0,
//     overflow_o -> 0. The holding register and valid_o are unaffected.
//   overflow_o is cleared only by reset or clear_i.
// CONFIGURATION
//   `DESER_PARITY_EN defined:
//     - Each frame is TO data bits plus one trailing even-parity bit.
//     - Extra state PARITY: the next bit_valid_i sampled in PARITY completes the word.
//     - Extra port parity_err_o (out, 1): loaded with the word, set if ^{word, parity bit} == 1.
//       Same valid/ready timing and overflow rules as data_o; reset value 0.
//   `DESER_PARITY_EN undefined: no PARITY state and no parity_err_o port.
//     The word completes on its TO-th bit.
// STRUCTURE
//   Package shift_ser_pkg contains:
//     - typedef enum logic [1:0] {IDLE, SHIFT, PARITY} deser_state_e
//     - function cnt_width(int n) returning $clog2(n+1)
//     - localparam PARITY_EVEN = 1'b0; the serializer shares the same package.
//   Sub-module deser_out_stage is the one-entry valid/ready holding register.
//     It owns the load, drop and overflow logic, is parameterised by width, and is reusable.
// TESTING
//   Test 1: TO=3, bits 1,0,1 on consecutive bit_valid_i, ready_i=1
//     -> data_o=3'b101 with valid_o high the cycle after the 3rd bit, for exactly 1 cycle.
//   Test 2: bits 0,1,1 with 2-cycle gaps (bit_valid_i low) between them
//     -> data_o=3'b011, busy_o high from the 1st bit through the 3rd bit.
//   Test 3: ready_i=0, send 3'b110 then 3'b001
//     -> data_o stays 3'b110 and overflow_o=1 after the 6th bit.
//     -> Raising ready_i gives one handshake, then valid_o=0.
//   Test 4: valid_o=1 holding 3'b111, ready_i=1 in the same cycle the 3rd bit of 3'b010 arrives
//     -> data_o=3'b010 next cycle, valid_o stays 1, overflow_o=0.
//   Test 5: two bits (1,1), then clear_i together with bit_valid_i, then bits 1,0,0
//     -> data_o=3'b100.
//     Separately, async reset after one bit -> all outputs 0 immediately.
//   Test 6 (`DESER_PARITY_EN): bits 1,0,1 then parity 0 -> data_o=3'b101, parity_err_o=0.
//     Bits 1,0,1 then parity 1 -> parity_err_o=1.

Source files
------------

// File: rtl/shift_ser_pkg.sv
// shift_ser_pkg: shared types and helpers for the serializer/deserializer pair
package shift_ser_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} deser_state_e;
  localparam logic PARITY_EVEN = 1'b0;
  function automatic int cnt_width(int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/deser_out_stage.sv
// deser_out_stage: one-entry valid/ready holding register with drop-on-full overflow flag
module deser_out_stage #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         clear_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         overflow_o
);
  logic accept;
  logic drop;
  assign accept = load_i && (!valid_o || ready_i);
  assign drop   = load_i && valid_o && !ready_i;
  // load a new word when the slot is empty or draining this cycle; flag words that find it full
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_o     <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (accept) data_o <= load_data_i;
      valid_o    <= accept ? 1'b1 : (ready_i ? 1'b0 : valid_o);
      overflow_o <= clear_i ? 1'b0 : (drop ? 1'b1 : overflow_o);
    end
  end
endmodule

// File: rtl/shift_deserializer.sv
// shift_deserializer: MSB-first serial-to-parallel stage; optional trailing even parity via DESER_PARITY_EN
module shift_deserializer
  import shift_ser_pkg::*;
#(
  parameter int TO = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bit_i,
  input  logic          bit_valid_i,
  input  logic          clear_i,
  output logic [TO-1:0] data_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          overflow_o,
`ifdef DESER_PARITY_EN
  output logic          parity_err_o,
`endif
  output logic          busy_o
);
  localparam int CW = cnt_width(TO);
`ifdef DESER_PARITY_EN
  localparam int OW = TO + 1;
`else
  localparam int OW = TO;
`endif
  if (TO < 2) begin : g_bad_to
    $error("shift_deserializer: TO must be >= 2");
  end
  deser_state_e  state_q, state_d;
  logic [TO-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done;
  logic [TO-1:0] word;
  logic [OW-1:0] out_word;
  logic [OW-1:0] held;
`ifdef DESER_PARITY_EN
  logic          perr;
`endif
  // state, shift register and bit counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end
  // next-state: clear aborts the word, otherwise each sampled bit shifts in until the word completes
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    word    = {sr_q[TO-2:0], bit_i};
`ifdef DESER_PARITY_EN
    perr    = 1'b0;
`endif
    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (bit_valid_i) begin
      case (state_q)
        IDLE: begin
          state_d = SHIFT;
          sr_d    = {{(TO-1){1'b0}}, bit_i};
          cnt_d   = CW'(1);
        end
        SHIFT: begin
          sr_d = word;
          if (cnt_q == CW'(TO - 1)) begin
`ifdef DESER_PARITY_EN
            state_d = PARITY;
            cnt_d   = CW'(TO);
`else
            state_d = IDLE;
            cnt_d   = '0;
            done    = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PARITY: begin
          state_d = IDLE;
          cnt_d   = '0;
`ifdef DESER_PARITY_EN
          done    = 1'b1;
          word    = sr_q;
          perr    = (^{sr_q, bit_i}) != PARITY_EVEN;
`endif
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end
`ifdef DESER_PARITY_EN
  assign out_word     = {perr, word};
  assign parity_err_o = held[TO];
`else
  assign out_word     = word;
`endif
  assign data_o = held[TO-1:0];
  assign busy_o = state_q != IDLE;
  deser_out_stage #(.W(OW)) u_out (
    .clk         (clk),
    .reset       (reset),
    .load_i      (done),
    .load_data_i (out_word),
    .clear_i     (clear_i),
    .ready_i     (ready_i),
    .data_o      (held),
    .valid_o     (valid_o),
    .overflow_o  (overflow_o)
  );
endmodule

// File: tb/tb_shift_deserializer.sv
// tb_shift_deserializer: directed self-checking bench for shift_deserializer (TO=3)
module tb_shift_deserializer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bit_i = 1'b0;
  logic       bit_valid_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       ready_i = 1'b1;
  logic [2:0] data_o;
  logic       valid_o;
  logic       overflow_o;
  logic       busy_o;
  int         errors = 0;
  int         checks = 0;
`ifdef DESER_PARITY_EN
  logic       parity_err_o;
`endif
  shift_deserializer #(.TO(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .bit_i       (bit_i),
    .bit_valid_i (bit_valid_i),
    .clear_i     (clear_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .overflow_o  (overflow_o),
`ifdef DESER_PARITY_EN
    .parity_err_o(parity_err_o),
`endif
    .busy_o      (busy_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic send(input logic b);
    bit_i = b;
    bit_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bit_valid_i = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    idle(2);
    check("reset_data", data_o, 3'b000);
    check("reset_valid", valid_o, 1'b0);
    check("reset_ovf", overflow_o, 1'b0);
    check("reset_busy", busy_o, 1'b0);
    reset = 1'b0;
    idle(1);
`ifndef DESER_PARITY_EN
    send(1); send(0);
    check("t1_busy_mid", busy_o, 1'b1);
    check("t1_valid_early", valid_o, 1'b0);
    send(1);
    check("t1_valid", valid_o, 1'b1);
    check("t1_data", data_o, 3'b101);
    check("t1_busy_done", busy_o, 1'b0);
    idle(1);
    check("t1_valid_pulse", valid_o, 1'b0);
    send(0); idle(2);
    check("t2_busy_gap1", busy_o, 1'b1);
    send(1); idle(2);
    check("t2_busy_gap2", busy_o, 1'b1);
    check("t2_valid_early", valid_o, 1'b0);
    send(1);
    check("t2_valid", valid_o, 1'b1);
    check("t2_data", data_o, 3'b011);
    idle(1);
    check("t2_valid_drop", valid_o, 1'b0);
    ready_i = 1'b0;
    send(1); send(1); send(0);
    check("t3_valid1", valid_o, 1'b1);
    check("t3_data1", data_o, 3'b110);
    check("t3_ovf_pre", overflow_o, 1'b0);
    send(0); send(0); send(1);
    check("t3_data_kept", data_o, 3'b110);
    check("t3_ovf", overflow_o, 1'b1);
    check("t3_valid_held", valid_o, 1'b1);
    ready_i = 1'b1;
    idle(1);
    check("t3_valid_after", valid_o, 1'b0);
    check("t3_ovf_sticky", overflow_o, 1'b1);
    clear_i = 1'b1;
    idle(1);
    clear_i = 1'b0;
    check("t3_ovf_cleared", overflow_o, 1'b0);
    ready_i = 1'b0;
    send(1); send(1); send(1);
    check("t4_data1", data_o, 3'b111);
    send(0); send(1);
    ready_i = 1'b1;
    send(0);
    check("t4_data2", data_o, 3'b010);
    check("t4_valid", valid_o, 1'b1);
    check("t4_ovf", overflow_o, 1'b0);
    idle(1);
    check("t4_valid_drop", valid_o, 1'b0);
    send(1); send(1);
    clear_i = 1'b1;
    send(1);
    clear_i = 1'b0;
    check("t5_busy_clear", busy_o, 1'b0);
    check("t5_no_word", valid_o, 1'b0);
    send(1); send(0);
    check("t5_valid_early", valid_o, 1'b0);
    send(0);
    check("t5_data", data_o, 3'b100);
    check("t5_valid", valid_o, 1'b1);
    idle(1);
`else
    send(1); send(0); send(1);
    check("t6_valid_early", valid_o, 1'b0);
    check("t6_busy_parity", busy_o, 1'b1);
    send(0);
    check("t6_valid", valid_o, 1'b1);
    check("t6_data", data_o, 3'b101);
    check("t6_perr0", parity_err_o, 1'b0);
    send(1); send(0); send(1); send(1);
    check("t6_data2", data_o, 3'b101);
    check("t6_perr1", parity_err_o, 1'b1);
    idle(1);
    check("t6_valid_drop", valid_o, 1'b0);
    send(0); send(1); send(1); send(0);
    check("t6_data3", data_o, 3'b011);
    check("t6_perr2", parity_err_o, 1'b0);
    idle(1);
`endif
    ready_i = 1'b0;
    send(1); send(0); send(1);
`ifdef DESER_PARITY_EN
    send(0);
`endif
    send(1);
    check("rst_pre_valid", valid_o, 1'b1);
    check("rst_pre_busy", busy_o, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_data", data_o, 3'b000);
    check("rst_async_valid", valid_o, 1'b0);
    check("rst_async_busy", busy_o, 1'b0);
    check("rst_async_ovf", overflow_o, 1'b0);
    #2 reset = 1'b0;
    ready_i = 1'b1;
    idle(1);
    send(0); send(1); send(0);
`ifdef DESER_PARITY_EN
    send(1);
`endif
    check("post_rst_data", data_o, 3'b010);
    check("post_rst_valid", valid_o, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
